// File: rtl/keypad_event_encoder.sv
// 12-key keypad debouncer/encoder feeding a 4-deep event FIFO with registered head outputs.
// Define KEYPAD_AUTOREPEAT_EN to emit repeat events while a key stays held.
module keypad_event_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_RATE     = 20
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [11:0] keypad_raw,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [11:0] key_onehot,
    input  logic        key_ready,
    output logic [2:0]  fifo_count,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES);

    function automatic logic [3:0] onehot_to_code(input logic [11:0] oh);
        logic [3:0] code;
        code = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (oh[i]) code = 4'(i + 1);
        end
        if (oh[9])  code = 4'd10;
        if (oh[11]) code = 4'd11;
        return code;
    endfunction

    function automatic logic [11:0] code_to_onehot(input logic [3:0] code);
        logic [11:0] oh;
        oh = 12'd0;
        case (code)
            4'd0:    oh = 12'h400;
            4'd10:   oh = 12'h200;
            4'd11:   oh = 12'h800;
            default: if (code <= 4'd9) oh = 12'(12'd1 << (code - 4'd1));
        endcase
        return oh;
    endfunction

    // Two-flop synchronizer; everything downstream sees only s.
    logic [11:0] sync1_q, sync2_q;
    logic [11:0] s;
    logic        s_onehot;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 12'd0;
            sync2_q <= 12'd0;
        end else begin
            sync1_q <= keypad_raw;
            sync2_q <= sync1_q;
        end
    end

    assign s        = sync2_q;
    assign s_onehot = (s != 12'd0) && ((s & (s - 12'd1)) == 12'd0);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  cnt_inc;
    logic [11:0] cap_q, cap_d;
    logic        push;
    logic [3:0]  push_code;

    assign cnt_inc   = cnt_q + 8'd1;
    assign push_code = onehot_to_code(cap_q);

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [15:0] RPT_DELAY_C = 16'(REPEAT_DELAY);
    localparam logic [15:0] RPT_RATE_C  = 16'(REPEAT_RATE);

    logic [15:0] rpt_q, rpt_d;
    logic [15:0] rpt_inc;
    logic        rpt_first_q, rpt_first_d;

    assign rpt_inc = rpt_q + 16'd1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rpt_q       <= 16'd0;
            rpt_first_q <= 1'b1;
        end else begin
            rpt_q       <= rpt_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`else
    // Repeat timing has no hardware in this build; the values are only range-tested here.
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_repeat_cfg_unused
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            cap_q   <= 12'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        push    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rpt_d       = rpt_q;
        rpt_first_d = rpt_first_q;
`endif
        case (state_q)
            IDLE: begin
                if (s_onehot) begin
                    cap_d   = s;
                    cnt_d   = 8'd1;
                    state_d = PRESS_DB;
                end
            end
            PRESS_DB: begin
                if (s == cap_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DB_LAST) begin
                        push    = 1'b1;
                        state_d = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rpt_d       = 16'd0;
                        rpt_first_d = 1'b1;
`endif
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            HELD: begin
                if (s == 12'd0) begin
                    cnt_d   = 8'd1;
                    state_d = RELEASE_DB;
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                else begin
                    rpt_d = rpt_inc;
                    if ((rpt_first_q && rpt_inc == RPT_DELAY_C) ||
                        (!rpt_first_q && rpt_inc == RPT_RATE_C)) begin
                        push        = 1'b1;
                        rpt_d       = 16'd0;
                        rpt_first_d = 1'b0;
                    end
                end
`endif
            end
            RELEASE_DB: begin
                // A bounce back to non-zero resumes HELD; the repeat counter just waits.
                if (s == 12'd0) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DB_LAST) state_d = IDLE;
                end else begin
                    state_d = HELD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic [3:0]  mem_q [4];
    logic [3:0]  mem_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        ovf_q, ovf_d;
    logic        valid_q, valid_d;
    logic [3:0]  code_q, code_d;
    logic [11:0] onehot_q, onehot_d;
    logic        pop;
    logic        push_acc;

    always_comb begin
        pop      = valid_q && key_ready;
        push_acc = push && ((count_q != 3'd4) || pop);
        wr_ptr_d = wr_ptr_q + {1'b0, push_acc};
        rd_ptr_d = rd_ptr_q + {1'b0, pop};
        count_d  = count_q + {2'b00, push_acc} - {2'b00, pop};
        ovf_d    = ovf_q || (push && !push_acc);
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_mem
        assign mem_d[gi] = (push_acc && (wr_ptr_q == 2'(gi))) ? push_code : mem_q[gi];
    end

    // Head outputs are registered from the next-state queue so they change only on push/pop.
    always_comb begin
        valid_d  = (count_d != 3'd0);
        code_d   = valid_d ? mem_d[rd_ptr_d] : 4'd0;
        onehot_d = valid_d ? code_to_onehot(code_d) : 12'd0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= 4'd0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            code_q   <= 4'd0;
            onehot_q <= 12'd0;
        end else begin
            for (int i = 0; i < 4; i++) mem_q[i] <= mem_d[i];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            code_q   <= code_d;
            onehot_q <= onehot_d;
        end
    end

    assign key_valid  = valid_q;
    assign key_code   = code_q;
    assign key_onehot = onehot_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: doc/keypad_event_encoder.md
KEYPAD_EVENT_ENCODER -- requirements
Module: keypad_event_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive identical synchronized samples required to accept a press or a release; legal range 2..255.
REQ-002 Parameter REPEAT_DELAY, default 50: cycles a key is held before the first auto-repeat event; used only with KEYPAD_AUTOREPEAT_EN.
REQ-003 Parameter REPEAT_RATE, default 20: cycles between later auto-repeat events; used only with KEYPAD_AUTOREPEAT_EN.
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 resetn  input  1  reset, asynchronous, active-low.
REQ-006 keypad_raw  input  12  asynchronous key lines, one bit per key: bits 0-8 = '1'-'9', bit 9 = '*', bit 10 = '0', bit 11 = '#'.
REQ-007 key_valid  output  1  high while the FIFO holds at least one event.
REQ-008 key_code  output  4  code of the head event: 0-9 = digit, 10 = '*', 11 = '#'; 12-15 never produced.
REQ-009 key_onehot  output  12  head event in the same one-hot form as keypad_raw, for direct use by the downstream menu/LCD stage.
REQ-010 key_ready  input  1  consumer accept; the head event is popped on a rising edge where key_valid and key_ready are both high.
REQ-011 fifo_count  output  3  number of queued events, 0..4.
REQ-012 overflow  output  1  sticky flag: an event was dropped because the FIFO was full.

Function
REQ-013 keypad_raw SHALL pass through a 2-flop synchronizer; S denotes the second-stage output, and all logic below uses S only.
REQ-014 The FSM SHALL have four states: IDLE, PRESS_DB, HELD and RELEASE_DB.
REQ-015 IDLE: S exactly one-hot -> capture S into cap, set cnt = 1, go to PRESS_DB; S zero or multi-hot -> stay in IDLE.
REQ-016 PRESS_DB: S == cap -> cnt += 1; S != cap -> go to IDLE with no event.
REQ-017 PRESS_DB: on the edge where cnt reaches DEBOUNCE_CYCLES, push the event for cap and go to HELD.
REQ-018 Press latency: key_valid SHALL rise after rising edge DEBOUNCE_CYCLES+2, counting from the first edge that samples a stable one-hot keypad_raw, when the FIFO was empty.
REQ-019 HELD: S == 0 -> cnt = 1, go to RELEASE_DB; any other S, including a second key or a different key -> stay in HELD with no event.
REQ-020 RELEASE_DB: S == 0 -> cnt += 1, and on reaching DEBOUNCE_CYCLES go to IDLE; S != 0 -> return to HELD with no event.
REQ-021 A new key SHALL be accepted only after a debounced release.
REQ-022 FIFO: depth 4, in-order, registered outputs; key_code and key_onehot SHALL be stable while key_valid is high and the head is not popped.
REQ-023 key_code and key_onehot SHALL be 0 when the FIFO is empty.
REQ-024 Push and pop on the same edge SHALL both take effect, with fifo_count unchanged; this includes the full case, which SHALL NOT set overflow.
REQ-025 Push while full with no pop SHALL drop the new event and set overflow; queue contents are unchanged.
REQ-026 Pop while empty SHALL have no effect; key_ready is ignored when key_valid is low.
REQ-027 Read and write pointers SHALL wrap modulo 4.

Reset
REQ-028 resetn low SHALL immediately set the FSM to IDLE, clear cnt, cap, the synchronizer, FIFO and pointers, and drive key_valid = 0, key_code = 0, key_onehot = 0, fifo_count = 0 and overflow = 0.
REQ-029 A key still held when resetn is released SHALL be treated as a new press and produce exactly one event after the normal debounce.
REQ-030 overflow SHALL be cleared only by reset.

Configuration
REQ-031 Macro KEYPAD_AUTOREPEAT_EN defined: in HELD, a repeat counter SHALL push a repeat of cap REPEAT_DELAY cycles after entering HELD, then every REPEAT_RATE cycles while the key is held.
REQ-032 The repeat counter SHALL reset on entering HELD and SHALL pause in RELEASE_DB.
REQ-033 Macro KEYPAD_AUTOREPEAT_EN undefined: HELD SHALL never push; there are no repeat counters and REPEAT_DELAY and REPEAT_RATE are unused.

Verification
REQ-034 Single press: keypad_raw = 12'h001 held for 10 cycles, key_ready = 1 -> key_valid high for exactly one cycle after edge 6, with key_code = 1 and key_onehot = 12'h001.
REQ-035 Bounce: keypad_raw toggles 12'h800 and 0 every 2 cycles, then holds 12'h800 for 20 cycles -> exactly one event, key_code = 11.
REQ-036 Mapping: press bit 10 then bit 9, each released for 10 cycles -> codes 0 then 10, in that order.
REQ-037 Overflow: key_ready = 0 and five distinct debounced presses -> fifo_count = 4 and overflow = 1; pops return the first four codes in order.
REQ-038 Multi-key and reset: 12'h003 for 20 cycles -> no event; then resetn pulsed low mid-PRESS_DB on 12'h004 with the key still held -> all outputs 0 during reset, then exactly one event with code 3.
REQ-039 Auto-repeat, with KEYPAD_AUTOREPEAT_EN, REPEAT_DELAY = 50, REPEAT_RATE = 20: hold 12'h010 for 100 cycles -> events with code 5 at the press, +50 and +70 cycles, plus one more if the 90-cycle point falls inside the hold; without the macro -> exactly one event.
